// File: rtl/spc2_pkg.sv
// Shared definitions for the spc2 configuration link: field widths, frame
// geometry, transmitter FSM states and the word packing helper.
package spc2_pkg;

   localparam int F_W     = 4;
   localparam int GS_W    = 4;
   localparam int GD_W    = 3;
   localparam int CFG_W   = 14;
   localparam int PAD_W   = 2;
   localparam int FRAME_W = CFG_W + PAD_W;

   typedef enum logic [1:0] {
      ST_LINK_RST = 2'd0,
      ST_IDLE     = 2'd1,
      ST_SHIFT    = 2'd2,
      ST_STROBE   = 2'd3
   } state_t;

   // MSB-first field order matches the receiver shift register layout.
   function automatic logic [CFG_W-1:0] pack_cfg(
      input logic [F_W-1:0]  f,
      input logic            iq,
      input logic [GS_W-1:0] gs,
      input logic            ce,
      input logic            ns,
      input logic [GD_W-1:0] gd
   );
      return {f, iq, gs, ce, ns, gd};
   endfunction

endpackage

// File: rtl/spc2_cfg_tx_if.sv
// Host-side request bus of the spc2 configuration transmitter: start/link
// reset requests, the configuration fields and the busy/done handshake.
interface spc2_cfg_tx_if;
   import spc2_pkg::*;

   logic            start;
   logic            link_rst;
   logic [F_W-1:0]  f;
   logic            iq;
   logic [GS_W-1:0] gs;
   logic            ce;
   logic            ns;
   logic [GD_W-1:0] gd;
   logic            busy;
   logic            done;

   modport master (
      output start, link_rst, f, iq, gs, ce, ns, gd,
      input  busy, done
   );

   modport slave (
      input  start, link_rst, f, iq, gs, ce, ns, gd,
      output busy, done
   );

endinterface

// File: rtl/spc2_sclk_gen.sv
// Half-period timer for cfg_clk: while enabled it ticks once every H_DIV
// cycles, marking the last cycle of the current clock phase.
module spc2_sclk_gen #(
   parameter int H_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_tick
);

   logic [7:0] r_cnt;
   logic       w_last;

   assign w_last = (r_cnt == 8'(H_DIV - 1));
   assign o_tick = i_en && w_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_en || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spc2_cfg_tx.sv
// spc2 configuration link transmitter: serialises one packed 14-bit word
// LSB first onto cfg_out/cfg_clk and manages the receiver link reset.
module spc2_cfg_tx
   import spc2_pkg::*;
#(
   parameter int H_DIV   = 4,
   parameter int RST_LEN = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   spc2_cfg_tx_if.slave host,
   output logic         o_cfg_out,
   output logic         o_cfg_clk,
   output logic         o_cfg_resetn
);

   localparam int              RC_W       = $clog2(RST_LEN);
   localparam logic [RC_W-1:0] RC_LAST    = RC_W'(RST_LEN - 1);
   localparam logic [4:0]      BITS_FIRST = 5'(CFG_W - 1);
   localparam logic [4:0]      BITS_LATER = 5'(FRAME_W - 1);

   state_t             r_state;
   logic [RC_W-1:0]    r_rstCnt;
   logic [FRAME_W-1:0] r_sr;
   logic [4:0]         r_bitCnt;
   logic               r_phaseHigh;
   logic               r_firstFrame;
   logic               r_busy;
   logic               r_done;
   logic               r_cfgOut;
   logic               r_cfgClk;
   logic               r_cfgResetn;

   logic               w_tick;
   logic               w_sclkEn;
   logic [CFG_W-1:0]   w_word;
   logic [FRAME_W-1:0] w_frame;

   assign w_sclkEn = (r_state == ST_SHIFT) || (r_state == ST_STROBE);
   assign w_word   = pack_cfg(host.f, host.iq, host.gs, host.ce, host.ns, host.gd);
   // The receiver counter resets to 14, so only later frames need the zero pads
   // to bring it back around to 0 after 16 shifts.
   assign w_frame  = r_firstFrame ? FRAME_W'(w_word) : {w_word, {PAD_W{1'b0}}};

   spc2_sclk_gen #(.H_DIV(H_DIV)) u_sclk (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_sclkEn),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_LINK_RST;
         r_rstCnt     <= '0;
         r_sr         <= '0;
         r_bitCnt     <= '0;
         r_phaseHigh  <= 1'b0;
         r_firstFrame <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cfgOut     <= 1'b0;
         r_cfgClk     <= 1'b0;
         r_cfgResetn  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // A link reset request outranks start and aborts any frame in flight.
         if (host.link_rst && (r_state != ST_LINK_RST)) begin
            r_state     <= ST_LINK_RST;
            r_rstCnt    <= '0;
            r_phaseHigh <= 1'b0;
            r_cfgOut    <= 1'b0;
            r_cfgClk    <= 1'b0;
            r_cfgResetn <= 1'b0;
         end else begin
            unique case (r_state)
               ST_LINK_RST: begin
                  r_cfgOut    <= 1'b0;
                  r_cfgClk    <= 1'b0;
                  r_cfgResetn <= 1'b0;
                  if (r_rstCnt == RC_LAST) begin
                     r_rstCnt     <= '0;
                     r_cfgResetn  <= 1'b1;
                     r_firstFrame <= 1'b1;
                     r_busy       <= 1'b0;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_rstCnt <= r_rstCnt + 1'b1;
                  end
               end
               ST_IDLE: begin
                  if (host.start) begin
                     r_sr        <= w_frame;
                     r_cfgOut    <= w_frame[0];
                     r_bitCnt    <= r_firstFrame ? BITS_FIRST : BITS_LATER;
                     r_phaseHigh <= 1'b0;
                     r_busy      <= 1'b1;
                     r_state     <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (w_tick) begin
                     if (!r_phaseHigh) begin
                        r_cfgClk    <= 1'b1;
                        r_phaseHigh <= 1'b1;
                     end else begin
                        r_cfgClk    <= 1'b0;
                        r_phaseHigh <= 1'b0;
                        if (r_bitCnt == 5'd0) begin
                           r_state <= ST_STROBE;
                        end else begin
                           r_sr     <= r_sr >> 1;
                           r_cfgOut <= r_sr[1];
                           r_bitCnt <= r_bitCnt - 5'd1;
                        end
                     end
                  end
               end
               ST_STROBE: begin
                  // Done is pulsed one cycle after the strobe low phase, still busy.
                  if (r_done) begin
                     r_busy       <= 1'b0;
                     r_firstFrame <= 1'b0;
                     r_state      <= ST_IDLE;
                  end else if (w_tick) begin
                     r_done <= 1'b1;
                  end
               end
               default: r_state <= ST_LINK_RST;
            endcase
         end
      end
   end

   assign host.busy    = r_busy;
   assign host.done    = r_done;
   assign o_cfg_out    = r_cfgOut;
   assign o_cfg_clk    = r_cfgClk;
   assign o_cfg_resetn = r_cfgResetn;

endmodule

// File: tb/tb_spc2_cfg_tx.sv
// Self-checking bench for spc2_cfg_tx: table vectors, random frames, link
// reset aborts and async reset, judged against a receiver-side model.
module tb_spc2_cfg_tx;

   localparam int H  = 2;
   localparam int RL = 8;

   typedef struct {
      logic [3:0]  f;
      logic        iq;
      logic [3:0]  gs;
      logic        ce;
      logic        ns;
      logic [2:0]  gd;
      logic [13:0] word;
      bit          hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cfgOut, cfgClk, cfgResetn;

   int vecCnt = 0;
   int errCnt = 0;
   int doneCnt = 0;
   int expFrames = 0;
   bit modelFirst = 1'b1;

   logic [13:0] rxSr = '0;
   logic [13:0] rxLatched = '0;
   int rxCnt = 14;
   int rxStrobes = 0;

   vec_t tbl [8];

   spc2_cfg_tx_if host ();

   spc2_cfg_tx #(.H_DIV(H), .RST_LEN(RL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host         (host.slave),
      .o_cfg_out    (cfgOut),
      .o_cfg_clk    (cfgClk),
      .o_cfg_resetn (cfgResetn)
   );

   always #5 clk = ~clk;

   // Receiver model: shift right from the MSB on each rising cfg_clk, 4-bit
   // down-counter reset to 14, latch on the falling edge after it reaches 0.
   always @(posedge cfgClk or negedge cfgResetn) begin
      if (!cfgResetn) begin
         rxCnt = 14;
      end else begin
         rxSr  = {cfgOut, rxSr[13:1]};
         rxCnt = (rxCnt + 15) % 16;
      end
   end

   always @(negedge cfgClk) begin
      if (cfgResetn === 1'b1 && rxCnt == 0) begin
         rxLatched = rxSr;
         rxStrobes++;
      end
   end

   always @(negedge clk) begin
      if (rst_n && host.done === 1'b1) doneCnt++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

   function automatic logic [13:0] packRef(input int f, iq, gs, ce, ns, gd);
      return 14'(f * 1024 + iq * 512 + gs * 32 + ce * 16 + ns * 8 + gd);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic countResetLow(output int n);
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (cfgResetn === 1'b1) break;
         n++;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] f, input logic iq, input logic [3:0] gs,
                                input logic ce, input logic ns, input logic [2:0] gd,
                                input logic [13:0] expWord, input bit hold, input string tag);
      int cyc, rises, timingErr, strobes0, expN, expDone;
      logic [15:0] obs, expBits;
      logic prevClk, prevOut;
      bit gotDone;
      expN     = modelFirst ? 14 : 16;
      expDone  = 1 + 2 * expN * H + H;
      expBits  = 16'(expWord) << (expN - 14);
      strobes0 = rxStrobes;
      @(negedge clk);
      host.f = f; host.iq = iq; host.gs = gs; host.ce = ce; host.ns = ns; host.gd = gd;
      host.start = 1'b1;
      @(negedge clk);
      cyc = 1;
      if (!hold) host.start = 1'b0;
      // Scramble the inputs: the captured word must not follow them.
      host.f = ~f; host.gd = ~gd;
      checkOutput({tag, " busy@t+1"}, 32'(host.busy), 32'd1);
      checkOutput({tag, " clk@t+1"}, 32'(cfgClk), 32'd0);
      checkOutput({tag, " bit0@t+1"}, 32'(cfgOut), 32'(expBits[0]));
      prevClk = cfgClk; prevOut = cfgOut;
      rises = 0; obs = '0; timingErr = 0; gotDone = 1'b0;
      while (!gotDone && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cfgClk === 1'b1 && prevClk === 1'b0) begin
            if (rises < 16) obs[rises] = cfgOut;
            if (cyc != 1 + 2 * rises * H + H) timingErr++;
            rises++;
         end
         if (cfgOut !== prevOut && !(prevClk === 1'b1 && cfgClk === 1'b0)) timingErr++;
         if (host.busy !== 1'b1) timingErr++;
         if (host.done === 1'b1) gotDone = 1'b1;
         prevClk = cfgClk; prevOut = cfgOut;
      end
      host.start = 1'b0;
      checkOutput({tag, " done latency"}, gotDone ? 32'(cyc) : 32'hFFFF_FFFF, 32'(expDone));
      checkOutput({tag, " edge count"}, 32'(rises), 32'(expN));
      checkOutput({tag, " serial bits"}, 32'(obs), 32'(expBits));
      checkOutput({tag, " timing errs"}, 32'(timingErr), 32'd0);
      checkOutput({tag, " rx strobes"}, 32'(rxStrobes - strobes0), 32'd1);
      checkOutput({tag, " rx word"}, 32'(rxLatched), 32'(expWord));
      @(negedge clk);
      checkOutput({tag, " busy after"}, 32'(host.busy), 32'd0);
      checkOutput({tag, " done after"}, 32'(host.done), 32'd0);
      modelFirst = 1'b0;
      expFrames++;
   endtask

   initial begin
      int lowCnt, cyc, rises, doneBefore, strobesBefore, busySeen;
      logic prevClk;

      tbl[0] = '{4'hA, 1'b1, 4'h5, 1'b0, 1'b1, 3'd6, 14'h2AAE, 1'b0};
      tbl[1] = '{4'hF, 1'b1, 4'hF, 1'b1, 1'b1, 3'd7, 14'h3FFF, 1'b0};
      tbl[2] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd1, 14'h0001, 1'b1};
      tbl[3] = '{4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 14'h2000, 1'b0};
      tbl[4] = '{4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 14'h0200, 1'b0};
      tbl[5] = '{4'h0, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0, 14'h01E0, 1'b0};
      tbl[6] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0, 14'h0010, 1'b0};
      tbl[7] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd4, 14'h000C, 1'b0};

      host.start = 1'b0; host.link_rst = 1'b0;
      host.f = '0; host.iq = 1'b0; host.gs = '0; host.ce = 1'b0; host.ns = 1'b0; host.gd = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset cfg_resetn", 32'(cfgResetn), 32'd0);
      checkOutput("reset cfg_clk", 32'(cfgClk), 32'd0);
      checkOutput("reset cfg_out", 32'(cfgOut), 32'd0);
      checkOutput("reset busy", 32'(host.busy), 32'd0);
      checkOutput("reset done", 32'(host.done), 32'd0);

      @(posedge clk); #1 rst_n = 1'b1;
      countResetLow(lowCnt);
      checkOutput("powerup link reset len", 32'(lowCnt), 32'(RL));
      checkOutput("powerup busy", 32'(host.busy), 32'd0);
      checkOutput("powerup cfg_clk", 32'(cfgClk), 32'd0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].f, tbl[i].iq, tbl[i].gs, tbl[i].ce, tbl[i].ns, tbl[i].gd,
                       tbl[i].word, tbl[i].hold, $sformatf("vec%0d", i));
         if (tbl[i].hold) begin
            busySeen = 0;
            repeat (10) begin
               @(negedge clk);
               if (host.busy === 1'b1) busySeen++;
            end
            checkOutput($sformatf("vec%0d held start ignored", i), 32'(busySeen), 32'd0);
         end
      end

      // Abort a 16-bit frame right after its 5th rising edge.
      doneBefore = doneCnt; strobesBefore = rxStrobes;
      @(negedge clk);
      host.f = 4'h3; host.iq = 1'b1; host.gs = 4'h9; host.start = 1'b1;
      @(negedge clk);
      host.start = 1'b0;
      prevClk = cfgClk; rises = 0; cyc = 0;
      while (rises < 5 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cfgClk === 1'b1 && prevClk === 1'b0) rises++;
         prevClk = cfgClk;
      end
      checkOutput("abort reached bit4", 32'(rises), 32'd5);
      host.link_rst = 1'b1;
      @(negedge clk);
      host.link_rst = 1'b0;
      checkOutput("abort cfg_clk low", 32'(cfgClk), 32'd0);
      checkOutput("abort cfg_resetn low", 32'(cfgResetn), 32'd0);
      countResetLow(lowCnt);
      checkOutput("abort link reset len", 32'(lowCnt + 1), 32'(RL));
      checkOutput("abort busy after", 32'(host.busy), 32'd0);
      checkOutput("abort no done", 32'(doneCnt - doneBefore), 32'd0);
      checkOutput("abort no rx strobe", 32'(rxStrobes - strobesBefore), 32'd0);
      modelFirst = 1'b1;
      applyStimulus(4'h5, 1'b0, 4'hC, 1'b1, 1'b0, 3'd3, packRef(5, 0, 12, 1, 0, 3), 1'b0, "post-abort");

      // link_rst and start together in IDLE: the link reset wins.
      @(negedge clk);
      host.start = 1'b1; host.link_rst = 1'b1;
      @(negedge clk);
      host.start = 1'b0; host.link_rst = 1'b0;
      checkOutput("race busy", 32'(host.busy), 32'd0);
      checkOutput("race cfg_resetn", 32'(cfgResetn), 32'd0);
      countResetLow(lowCnt);
      checkOutput("race link reset len", 32'(lowCnt + 1), 32'(RL));
      modelFirst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         int rf, riq, rgs, rce, rns, rgd;
         rf = $urandom_range(0, 15); riq = $urandom_range(0, 1); rgs = $urandom_range(0, 15);
         rce = $urandom_range(0, 1); rns = $urandom_range(0, 1); rgd = $urandom_range(0, 7);
         applyStimulus(4'(rf), 1'(riq), 4'(rgs), 1'(rce), 1'(rns), 3'(rgd),
                       packRef(rf, riq, rgs, rce, rns, rgd), 1'b0, $sformatf("rand%0d", i));
      end

      // Asynchronous reset in the middle of a frame.
      @(negedge clk);
      host.f = 4'hF; host.iq = 1'b1; host.gs = 4'hF; host.ce = 1'b1; host.ns = 1'b1; host.gd = 3'd7;
      host.start = 1'b1;
      @(negedge clk);
      host.start = 1'b0;
      prevClk = cfgClk; rises = 0; cyc = 0;
      while (rises < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (cfgClk === 1'b1 && prevClk === 1'b0) rises++;
         prevClk = cfgClk;
      end
      checkOutput("midreset reached bit3", 32'(rises), 32'd4);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset cfg_resetn", 32'(cfgResetn), 32'd0);
      checkOutput("midreset cfg_clk", 32'(cfgClk), 32'd0);
      checkOutput("midreset cfg_out", 32'(cfgOut), 32'd0);
      checkOutput("midreset busy", 32'(host.busy), 32'd0);
      checkOutput("midreset done", 32'(host.done), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      countResetLow(lowCnt);
      checkOutput("midreset link reset len", 32'(lowCnt), 32'(RL));
      modelFirst = 1'b1;
      applyStimulus(4'h6, 1'b1, 4'h2, 1'b0, 1'b1, 3'd5, packRef(6, 1, 2, 0, 1, 5), 1'b0, "post-reset");

      checkOutput("total done pulses", 32'(doneCnt), 32'(expFrames));

      $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
      $finish;
   end

endmodule
